// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload, valid and hazard metadata, plus forwarding queries.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W     = 64,
    parameter int unsigned TNEW_W        = 2,
    parameter int unsigned TNEW_DEC      = 1,
    parameter int unsigned NQ            = 2,
    parameter int unsigned CLEAR_PAYLOAD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_regwrite,
    input  logic [4:0]           in_wa,
    input  logic [TNEW_W-1:0]    in_tnew,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_regwrite,
    output logic [4:0]           out_wa,
    output logic [TNEW_W-1:0]    out_tnew,
    input  logic [NQ*5-1:0]      query_addr,
    output logic [NQ-1:0]        fwd_hit,
    output logic [NQ-1:0]        fwd_ready,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
);

    logic                 valid_q,    valid_d;
    logic [PAYLOAD_W-1:0] payload_q,  payload_d;
    logic                 regwrite_q, regwrite_d;
    logic [4:0]           wa_q,       wa_d;
    logic [TNEW_W-1:0]    tnew_q,     tnew_d;

    logic [31:0]          tnew_ext;
    logic [TNEW_W-1:0]    tnew_loaded;

    // Widen before subtracting so TNEW_DEC larger than the field cannot wrap.
    assign tnew_ext    = 32'(in_tnew);
    assign tnew_loaded = (tnew_ext > TNEW_DEC) ? TNEW_W'(tnew_ext - TNEW_DEC) : '0;

    always_comb begin
        valid_d    = valid_q;
        payload_d  = payload_q;
        regwrite_d = regwrite_q;
        wa_d       = wa_q;
        tnew_d     = tnew_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            wa_d       = '0;
            tnew_d     = '0;
            if (CLEAR_PAYLOAD != 0) begin
                payload_d = '0;
            end
        end else if (en) begin
            valid_d    = in_valid;
            payload_d  = in_payload;
            regwrite_d = in_regwrite & in_valid;
            wa_d       = in_valid ? in_wa : 5'd0;
            tnew_d     = tnew_loaded;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            payload_q  <= '0;
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            tnew_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            payload_q  <= payload_d;
            regwrite_q <= regwrite_d;
            wa_q       <= wa_d;
            tnew_q     <= tnew_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_payload  = payload_q;
    assign out_regwrite = regwrite_q;
    assign out_wa       = wa_q;
    assign out_tnew     = tnew_q;

    logic stage_writes;
    logic tnew_zero;

    // $0 is hardwired to zero, so it is never a forwarding source.
    assign stage_writes = valid_q & regwrite_q & (wa_q != 5'd0);
    assign tnew_zero    = (tnew_q == '0);

    always_comb begin
        fwd_hit   = '0;
        fwd_ready = '0;
        for (int k = 0; k < NQ; k++) begin
            fwd_hit[k]   = stage_writes & (wa_q == query_addr[5*k +: 5]);
            fwd_ready[k] = fwd_hit[k] & tnew_zero;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        stall_evt;
    logic        bubble_evt;

    // A stall only counts when it is actually holding a live instruction.
    assign stall_evt  = ~flush & ~en & valid_q;
    assign bubble_evt = flush | (en & ~in_valid);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a behavioural model of the stage rules.
module tb_pipe_stage_reg;

    localparam int unsigned DEC = 1;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, en, flush, in_valid, in_regwrite;
    logic [63:0] in_payload;
    logic [4:0]  in_wa;
    logic [1:0]  in_tnew;
    logic [9:0]  query_addr;

    logic        a_valid, a_regwrite, b_valid, b_regwrite;
    logic [63:0] a_payload, b_payload;
    logic [4:0]  a_wa, b_wa;
    logic [1:0]  a_tnew, b_tnew, a_hit, a_ready, b_hit, b_ready;
    logic [31:0] a_stall, a_bubble, b_stall, b_bubble;

    pipe_stage_reg #(.CLEAR_PAYLOAD(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .in_regwrite(in_regwrite), .in_wa(in_wa), .in_tnew(in_tnew),
        .out_valid(a_valid), .out_payload(a_payload), .out_regwrite(a_regwrite),
        .out_wa(a_wa), .out_tnew(a_tnew), .query_addr(query_addr), .fwd_hit(a_hit),
        .fwd_ready(a_ready), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(.CLEAR_PAYLOAD(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_payload(in_payload), .in_regwrite(in_regwrite), .in_wa(in_wa), .in_tnew(in_tnew),
        .out_valid(b_valid), .out_payload(b_payload), .out_regwrite(b_regwrite),
        .out_wa(b_wa), .out_tnew(b_tnew), .query_addr(query_addr), .fwd_hit(b_hit),
        .fwd_ready(b_ready), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit          m_valid, m_regwrite;
    logic [63:0] m_payload, m_payload_keep;
    int          m_wa, m_tnew;
    longint      m_stall, m_bubble;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_valid = 0; m_regwrite = 0; m_payload = 0; m_payload_keep = 0;
            m_wa = 0; m_tnew = 0; m_stall = 0; m_bubble = 0;
        end else begin
            if (!flush && !en && m_valid && m_stall < 64'hFFFF_FFFF) m_stall++;
            if ((flush || (en && !in_valid)) && m_bubble < 64'hFFFF_FFFF) m_bubble++;
            if (flush) begin
                m_valid = 0; m_regwrite = 0; m_wa = 0; m_tnew = 0; m_payload = 0;
            end else if (en) begin
                m_valid        = in_valid;
                m_payload      = in_payload;
                m_payload_keep = in_payload;
                m_regwrite     = in_regwrite && in_valid;
                m_wa           = in_valid ? int'(in_wa) : 0;
                m_tnew         = (int'(in_tnew) > DEC) ? int'(in_tnew) - DEC : 0;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] exp_hit, exp_ready;
        int qa;
        for (int k = 0; k < 2; k++) begin
            qa = int'(query_addr[5*k +: 5]);
            exp_hit[k]   = m_valid && m_regwrite && m_wa != 0 && m_wa == qa;
            exp_ready[k] = exp_hit[k] && m_tnew == 0;
        end
        check("valid",    64'(a_valid),    64'(m_valid));
        check("payload",  a_payload,       m_payload);
        check("regwrite", 64'(a_regwrite), 64'(m_regwrite));
        check("wa",       64'(a_wa),       64'(m_wa));
        check("tnew",     64'(a_tnew),     64'(m_tnew));
        check("fwd_hit",  64'(a_hit),      64'(exp_hit));
        check("fwd_ready", 64'(a_ready),   64'(exp_ready));
        check("stall_cnt", 64'(a_stall),   PERF ? 64'(m_stall) : 64'd0);
        check("bubble_cnt", 64'(a_bubble), PERF ? 64'(m_bubble) : 64'd0);
        check("keep_payload", b_payload,   m_payload_keep);
        check("keep_valid", 64'(b_valid),  64'(m_valid));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] wa, input logic [1:0] tn,
                         input logic [63:0] pl);
        in_valid = v; in_regwrite = rw; in_wa = wa; in_tnew = tn; in_payload = pl;
    endtask

    initial begin
        reset = 1; en = 1; flush = 0; query_addr = '0;
        drive(0, 0, 5'd0, 2'd0, 64'd0);
        @(negedge clk);
        cycle();
        reset = 0;

        // Reset clears a freshly loaded stage.
        drive(1, 1, 5'd3, 2'd2, 64'hDEAD);
        query_addr = {5'd3, 5'd3};
        cycle();
        reset = 1;
        cycle();
        reset = 0;

        // Load with Tnew countdown and saturation.
        query_addr = {5'd8, 5'd9};
        drive(1, 1, 5'd8, 2'd2, 64'h1111);
        cycle();
        drive(1, 1, 5'd8, 2'd1, 64'h2222);
        cycle();
        drive(1, 1, 5'd8, 2'd0, 64'h3333);
        cycle();

        // Stall holds for three cycles with Tnew frozen at 1.
        drive(1, 1, 5'd9, 2'd2, 64'h4444);
        cycle();
        en = 0;
        drive(1, 1, 5'd7, 2'd0, 64'h5555);
        repeat (3) cycle();

        // Flush overrides stall.
        flush = 1;
        cycle();
        flush = 0; en = 1;

        // $0 never hits; invalid instruction drops regwrite and wa.
        query_addr = {5'd5, 5'd0};
        drive(1, 1, 5'd0, 2'd0, 64'h6666);
        cycle();
        drive(0, 1, 5'd5, 2'd0, 64'h7777);
        cycle();

`ifdef PIPE_STAGE_PERF_EN
        force dut_a.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut_a.bubble_cnt_q;
        m_bubble = 64'hFFFF_FFFE;
        flush = 1;
        repeat (3) cycle();
        flush = 0;
        reset = 1;
        cycle();
        reset = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(31) == 0);
            flush       = ($urandom_range(7) == 0);
            en          = ($urandom_range(3) != 0);
            in_valid    = ($urandom_range(4) != 0);
            in_regwrite = $urandom_range(1) == 1;
            in_payload  = {$urandom, $urandom};
            in_wa       = 5'($urandom_range(7));
            in_tnew     = 2'($urandom_range(3));
            query_addr  = {5'($urandom_range(7)), 5'($urandom_range(7))};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
